// File: rtl/bus_fifo_slave.sv
// rtl/bus_fifo_slave.sv - bus register slave feeding a byte FIFO drained by a local consumer
module bus_fifo_slave #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_cs_,
  input  logic        s_as_,
  input  logic        s_rw,
  input  logic [29:0] s_addr,
  input  logic [31:0] s_wr_data,
  output logic [31:0] s_rd_data,
  output logic        s_rdy_,
  input  logic        fifo_pop,
  output logic [7:0]  fifo_data,
  output logic        fifo_empty,
  output logic        fifo_full
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_SPACE} state_t;

  localparam logic [1:0]       OFF_DATA   = 2'd0;
  localparam logic [1:0]       OFF_STATUS = 2'd1;
  localparam logic [1:0]       OFF_CTRL   = 2'd2;
  localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  state_t           state, next_state;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [8:0]       count_ext;
  logic             cap_rw;
  logic [1:0]       cap_off;
  logic [7:0]       cap_byte;
  logic             start, data_wr, flush, push, pop;
  logic [7:0]       push_data;
  logic             rdy_d;
  logic [31:0]      rd_d;
  logic             unused_bits;

  assign unused_bits = ^{s_addr[29:2], s_wr_data[31:8]};

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign fifo_data  = mem[rd_ptr];
  assign count_ext  = 9'(count);

  assign start   = (state == IDLE) && !s_cs_ && !s_as_;
  assign data_wr = !s_rw && (s_addr[1:0] == OFF_DATA);
  assign flush   = start && !s_rw && (s_addr[1:0] == OFF_CTRL) && s_wr_data[0];
  // A stalled write pushes the byte captured at its start edge, not the live bus.
  assign push    = (start && data_wr && !fifo_full) ||
                   ((state == WAIT_SPACE) && !fifo_full && !cap_rw && (cap_off == OFF_DATA));
  assign push_data = (state == WAIT_SPACE) ? cap_byte : s_wr_data[7:0];
  assign pop     = fifo_pop && !fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s_rdy_    <= 1'b1;
      s_rd_data <= '0;
      cap_rw    <= 1'b0;
      cap_off   <= '0;
      cap_byte  <= '0;
    end else begin
      state     <= next_state;
      s_rdy_    <= rdy_d;
      s_rd_data <= rd_d;
      if (start) begin
        cap_rw   <= s_rw;
        cap_off  <= s_addr[1:0];
        cap_byte <= s_wr_data[7:0];
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (start) next_state = (data_wr && fifo_full) ? WAIT_SPACE : ACK;
      WAIT_SPACE: if (!fifo_full) next_state = ACK;
      ACK:        next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    rdy_d = (next_state != ACK);
    rd_d  = '0;
    if (start && s_rw && (s_addr[1:0] == OFF_STATUS))
      rd_d = {15'b0, count_ext, 6'b0, fifo_full, fifo_empty};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Flush wins over any push or pop landing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
